// File: rtl/pmod_keypad_scanner.sv
// pmod_keypad_scanner
// Scans a 4x4 Pmod KYPD matrix one column at a time, rejects multi-key
// (ghost) patterns, debounces whole-scan results and publishes a hex key
// code with a valid level and a one-clk press pulse.
//
// Build option: KEYPAD_ROW_SYNC_EN
//   defined   -> rows pass through a 2-flop synchronizer before sampling
//   undefined -> rows are sampled directly (external synchronizer assumed)
// The sample point is the last tick of each column either way, so accept
// timing does not depend on the option.
//
// state | meaning
// IDLE  | no key accepted
// CAND  | candidate key seen, counting matching scans
// HELD  | key accepted; differing results must persist to take effect
module pmod_keypad_scanner #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] dec,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, CAND, HELD} state_t;

  logic [3:0]    row_smp;
  logic          running;
  logic [1:0]    c;
  logic [TW-1:0] tick;
  logic          sample;
  logic          last;
  logic [2:0]    col_lows;
  logic [1:0]    col_row;
  logic [1:0]    col_sat;
  logic [2:0]    sum;
  logic [1:0]    scan_total;
  logic [3:0]    scan_key;
  logic          res_none;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_key;
  state_t        state;
  logic [3:0]    cand;
  logic          cand_none;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          track_same;

  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] cc);
    logic [3:0] k;
    case ({r, cc})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

`ifdef KEYPAD_ROW_SYNC_EN
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  // two-flop synchronizer on the asynchronous keypad rows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign row_smp = row_sync;
`else
  assign row_smp = row;
`endif

  // column driver and per-column tick counter; first clk after reset
  // only arms the scan so column 0 gets a full SCAN_TICKS settle window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      c       <= 2'd0;
      tick    <= '0;
      col     <= 4'b1111;
    end else if (!running) begin
      running <= 1'b1;
      col     <= 4'b1110;
    end else if (tick == TICK_LAST) begin
      tick <= '0;
      c    <= c + 2'd1;
      col  <= ~(4'b0001 << (c + 2'd1));
    end else begin
      tick <= tick + TW'(1);
    end
  end

  assign sample = running && (tick == TICK_LAST);
  assign last   = sample && (c == 2'd3);

  // count low rows in the driven column and locate the (single) low row
  always_comb begin
    col_lows = 3'd0;
    col_row  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row_smp[i]) begin
        col_lows = col_lows + 3'd1;
        col_row  = 2'(i);
      end
    end
  end

  // fold this column into the running scan result; count saturates at 2
  always_comb begin
    col_sat    = (col_lows >= 3'd2) ? 2'd2 : col_lows[1:0];
    sum        = {1'b0, acc_cnt} + {1'b0, col_sat};
    scan_total = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    scan_key   = (col_lows == 3'd1) ? key_at(col_row, c) : acc_key;
    res_none   = (scan_total != 2'd1);
  end

  // per-scan accumulator, cleared as each full scan completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 2'd0;
      acc_key <= 4'h0;
    end else if (last) begin
      acc_cnt <= 2'd0;
      acc_key <= 4'h0;
    end else if (sample) begin
      acc_cnt <= scan_total;
      acc_key <= scan_key;
    end
  end

  assign cnt_inc    = cnt + CW'(1);
  assign track_same = (cnt != '0) && (res_none == cand_none) &&
                      (res_none || (scan_key == cand));

  // debounce FSM, evaluated once per completed scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cand        <= 4'h0;
      cand_none   <= 1'b0;
      cnt         <= '0;
      dec         <= 4'h0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      key_pressed <= 1'b0;
      if (last) begin
        case (state)
          IDLE: begin
            if (!res_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                state       <= HELD;
                cnt         <= '0;
                dec         <= scan_key;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
              end else begin
                state     <= CAND;
                cand      <= scan_key;
                cand_none <= 1'b0;
                cnt       <= CW'(1);
              end
            end
          end
          CAND: begin
            if (res_none) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (scan_key == cand) begin
              if (cnt_inc == CNT_DONE) begin
                state       <= HELD;
                cnt         <= '0;
                dec         <= cand;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cand <= scan_key;
              cnt  <= CW'(1);
            end
          end
          HELD: begin
            if (!res_none && (scan_key == dec)) begin
              cnt <= '0;
            end else if ((track_same ? cnt_inc : CW'(1)) == CNT_DONE) begin
              cnt <= '0;
              if (res_none) begin
                state     <= IDLE;
                key_valid <= 1'b0;
              end else begin
                dec         <= scan_key;
                key_pressed <= 1'b1;
              end
            end else begin
              cnt       <= track_same ? cnt_inc : CW'(1);
              cand      <= scan_key;
              cand_none <= res_none;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
